// File: rtl/gpio_pkg.sv
// Shared register map and constants for the GPIO controller and its
// interrupt companion block.
package gpio_pkg;

    localparam int ADDRWIDTH = 8;

    localparam logic [31:0] DEFAULT_REG_VALUE = 32'hFABDEFAC;

    localparam logic [ADDRWIDTH-1:0] GPIO_IN  = 8'h00;
    localparam logic [ADDRWIDTH-1:0] GPIO_OUT = 8'h04;
    localparam logic [ADDRWIDTH-1:0] GPIO_OE  = 8'h08;

    localparam logic [ADDRWIDTH-1:0] SYNC_IN  = 8'h00;
    localparam logic [ADDRWIDTH-1:0] IRQ_EN   = 8'h04;
    localparam logic [ADDRWIDTH-1:0] IRQ_TYPE = 8'h08;
    localparam logic [ADDRWIDTH-1:0] IRQ_POL  = 8'h0C;
    localparam logic [ADDRWIDTH-1:0] IRQ_STAT = 8'h10;
    localparam logic [ADDRWIDTH-1:0] IRQ_PEND = 8'h14;

    function automatic logic [31:0] byte_mask(input logic [3:0] bs);
        return {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
    endfunction

endpackage

// File: rtl/gpio_irq_controller_if.sv
// Wishbone slave bundle shared by the GPIO blocks on the
// AHB-to-FPGA bridge.
interface gpio_irq_controller_if;

    logic [16:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  byte_stb;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output adr, cyc, stb, we, byte_stb, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  adr, cyc, stb, we, byte_stb, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser with previous-sample flop and per-bit
// edge/level event generation.
module gpio_sync_edge #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic [W-1:0] irq_type,
    input  logic [W-1:0] irq_pol,
    output logic [W-1:0] sync,
    output logic [W-1:0] evt
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] prev;
    logic [1:0]   cnt;
    logic         valid;

    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] edge_evt;
    logic [W-1:0] lvl_evt;

    // prev first holds a real pin sample the cycle after cnt saturates,
    // so valid lags the count by one flop to block reset-time edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            prev  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            prev  <= s2;
            valid <= (cnt == 2'd2);
            if (cnt != 2'd2)
                cnt <= cnt + 2'd1;
        end
    end

    assign rise     = s2 & ~prev;
    assign fall     = ~s2 & prev;
    assign edge_evt = {W{valid}} & ((irq_pol & rise) | (~irq_pol & fall));
    assign lvl_evt  = ~(irq_pol ^ s2);
    assign evt      = (irq_type & lvl_evt) | (~irq_type & edge_evt);
    assign sync     = s2;

endmodule

// File: rtl/gpio_irq_controller.sv
// GPIO interrupt controller: Wishbone register file, sticky status
// and registered interrupt line.
module gpio_irq_controller #(
    parameter logic [16:0] MODULE_OFFSET     = 17'h0_1100,
    parameter logic [31:0] DEFAULT_REG_VALUE = gpio_pkg::DEFAULT_REG_VALUE
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    gpio_irq_controller_if.slave bus,
    input  logic [31:0]          GPIO_in,
    output logic                 IRQ_o
);

    import gpio_pkg::*;

    localparam int OW = ADDRWIDTH - 2;

    localparam logic [OW-1:0] A_SYNC = SYNC_IN[ADDRWIDTH-1:2];
    localparam logic [OW-1:0] A_EN   = IRQ_EN[ADDRWIDTH-1:2];
    localparam logic [OW-1:0] A_TYPE = IRQ_TYPE[ADDRWIDTH-1:2];
    localparam logic [OW-1:0] A_POL  = IRQ_POL[ADDRWIDTH-1:2];
    localparam logic [OW-1:0] A_STAT = IRQ_STAT[ADDRWIDTH-1:2];
    localparam logic [OW-1:0] A_PEND = IRQ_PEND[ADDRWIDTH-1:2];

    logic [31:0]   en;
    logic [31:0]   typ;
    logic [31:0]   pol;
    logic [31:0]   stat;
    logic [31:0]   sync;
    logic [31:0]   evt;
    logic [31:0]   wmask;
    logic [31:0]   w1c;
    logic [31:0]   rdata;
    logic [OW-1:0] off;
    logic          decode;
    logic          req;
    logic          wr;
    logic          ack;
    logic          unused_adr;

    assign off    = bus.adr[ADDRWIDTH-1:2];
    assign decode = (bus.adr[16:ADDRWIDTH] == MODULE_OFFSET[16:ADDRWIDTH]);
    assign req    = decode & bus.cyc & bus.stb & ~ack;
    assign wr     = req & bus.we;
    assign wmask  = byte_mask(bus.byte_stb);
    assign w1c    = (wr && off == A_STAT) ? (bus.dat_w & wmask) : '0;

    assign unused_adr = ^bus.adr[1:0];

    gpio_sync_edge #(
        .W (32)
    ) u_sync (
        .clk      (WBs_CLK_i),
        .rst      (WBs_RST_i),
        .din      (GPIO_in),
        .irq_type (typ),
        .irq_pol  (pol),
        .sync     (sync),
        .evt      (evt)
    );

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ack   <= 1'b0;
            en    <= '0;
            typ   <= '0;
            pol   <= '0;
            stat  <= '0;
            IRQ_o <= 1'b0;
        end else begin
            ack <= req;
            if (wr && off == A_EN)
                en <= (en & ~wmask) | (bus.dat_w & wmask);
            if (wr && off == A_TYPE)
                typ <= (typ & ~wmask) | (bus.dat_w & wmask);
            if (wr && off == A_POL)
                pol <= (pol & ~wmask) | (bus.dat_w & wmask);
            // Level bits track the condition; edge bits are sticky
            // and a new event wins over a same-cycle clear.
            stat  <= evt | (~typ & stat & ~w1c);
            IRQ_o <= |(stat & en);
        end
    end

    always_comb begin
        rdata = DEFAULT_REG_VALUE;
        unique case (1'b1)
            (off == A_SYNC): rdata = sync;
            (off == A_EN):   rdata = en;
            (off == A_TYPE): rdata = typ;
            (off == A_POL):  rdata = pol;
            (off == A_STAT): rdata = stat;
            (off == A_PEND): rdata = stat & en;
            default:         rdata = DEFAULT_REG_VALUE;
        endcase
    end

    assign bus.dat_r = rdata;
    assign bus.ack   = ack;

endmodule
